// File: rtl/key_gate_debounce.sv
// Push-button conditioner: two-stage synchronisers, a debounce FSM and a fixed-width gate
// pulse with a sampled data level, driving a downstream level-sensitive latch.
module key_gate_debounce #(
   parameter logic [19:0] CNT_MAX        = 20'd999_999,
   parameter int unsigned GATE_LEN       = 4,
   parameter bit          KEY_ACTIVE_LOW = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_in,
   input  logic       sw_in,
   output logic       d_out,
   output logic       gate_out,
   output logic       key_state,
   output logic [7:0] press_cnt
);

   localparam int unsigned CW = ($clog2(int'(CNT_MAX) + 1) > 0) ? $clog2(int'(CNT_MAX) + 1) : 1;
   localparam int unsigned GW = (GATE_LEN > 1) ? $clog2(GATE_LEN) : 1;

   localparam logic [CW-1:0] CntMaxW  = CW'(CNT_MAX);
   localparam logic [GW-1:0] GateLoad = GW'(GATE_LEN - 1);
   localparam logic          KeyRel   = logic'(KEY_ACTIVE_LOW);

   localparam logic [1:0] StIdle    = 2'd0;
   localparam logic [1:0] StDbPress = 2'd1;
   localparam logic [1:0] StPressed = 2'd2;
   localparam logic [1:0] StDbRel   = 2'd3;

   logic          r_key_s1, r_key_s2;
   logic          r_sw_s1, r_sw_s2;
   logic [1:0]    r_state;
   logic [CW-1:0] r_cnt;
   logic          r_key_state;
   logic          r_d;
   logic          r_gate;
   logic [GW-1:0] r_gate_cnt;
   logic [7:0]    r_press_cnt;

   logic          w_key_s;
   logic [1:0]    w_state_d;
   logic [CW-1:0] w_cnt_d;
   logic          w_qualify;

   // Key synchronisers reset to the released level so reset never looks like a press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_key_s1 <= KeyRel;
         r_key_s2 <= KeyRel;
         r_sw_s1  <= 1'b0;
         r_sw_s2  <= 1'b0;
      end else begin
         r_key_s1 <= key_in;
         r_key_s2 <= r_key_s1;
         r_sw_s1  <= sw_in;
         r_sw_s2  <= r_sw_s1;
      end
   end

   assign w_key_s = KEY_ACTIVE_LOW ? ~r_key_s2 : r_key_s2;

   always_comb begin
      w_state_d = r_state;
      w_cnt_d   = r_cnt;
      w_qualify = 1'b0;
      case (r_state)
         StIdle: begin
            if (w_key_s) begin
               w_state_d = StDbPress;
               w_cnt_d   = '0;
            end
         end
         StDbPress: begin
            if (!w_key_s) begin
               w_state_d = StIdle;
               w_cnt_d   = '0;
            end else if (r_cnt == CntMaxW) begin
               w_state_d = StPressed;
               w_qualify = 1'b1;
            end else begin
               w_cnt_d = r_cnt + CW'(1);
            end
         end
         StPressed: begin
            if (!w_key_s) begin
               w_state_d = StDbRel;
               w_cnt_d   = '0;
            end
         end
         StDbRel: begin
            if (w_key_s) begin
               w_state_d = StPressed;
               w_cnt_d   = '0;
            end else if (r_cnt == CntMaxW) begin
               w_state_d = StIdle;
            end else begin
               w_cnt_d = r_cnt + CW'(1);
            end
         end
         default: begin
            w_state_d = StIdle;
            w_cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= StIdle;
         r_cnt       <= '0;
         r_key_state <= 1'b0;
      end else begin
         r_state     <= w_state_d;
         r_cnt       <= w_cnt_d;
         r_key_state <= (w_state_d == StPressed) || (w_state_d == StDbRel);
      end
   end

   // A qualify edge during an active gate reloads the counter, stretching the pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_d         <= 1'b0;
         r_gate      <= 1'b0;
         r_gate_cnt  <= '0;
         r_press_cnt <= 8'd0;
      end else if (w_qualify) begin
         r_d         <= r_sw_s2;
         r_gate      <= 1'b1;
         r_gate_cnt  <= GateLoad;
         r_press_cnt <= r_press_cnt + 8'd1;
      end else if (r_gate) begin
         if (r_gate_cnt == '0) begin
            r_gate <= 1'b0;
         end else begin
            r_gate_cnt <= r_gate_cnt - GW'(1);
         end
      end
   end

   assign d_out     = r_d;
   assign gate_out  = r_gate;
   assign key_state = r_key_state;
   assign press_cnt = r_press_cnt;

endmodule

// File: tb/tb_key_gate_debounce.sv
// Directed bench for key_gate_debounce with CNT_MAX=9, GATE_LEN=4, active-low key.
module tb_key_gate_debounce;

   logic       clk;
   logic       rst_n;
   logic       key_in;
   logic       sw_in;
   logic       d_out;
   logic       gate_out;
   logic       key_state;
   logic [7:0] press_cnt;

   int         n_tests;
   int         n_fail;
   int         gate_rises;
   int         gate_hi;
   logic       gate_prev;
   logic [7:0] exp_cnt;
   int         rises0;
   int         hi0;

   key_gate_debounce #(
      .CNT_MAX        (20'd9),
      .GATE_LEN       (4),
      .KEY_ACTIVE_LOW (1'b1)
   ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_in    (key_in),
      .sw_in     (sw_in),
      .d_out     (d_out),
      .gate_out  (gate_out),
      .key_state (key_state),
      .press_cnt (press_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts gate pulses and gate-high cycles, sampled mid-cycle.
   initial begin
      gate_rises = 0;
      gate_hi    = 0;
      gate_prev  = 1'b0;
      forever begin
         @(negedge clk);
         if (gate_out && !gate_prev) gate_rises++;
         if (gate_out) gate_hi++;
         gate_prev = gate_out;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Full press/release with edge-exact checks; key_in falls just after an edge.
   task automatic press_checked(input logic sw, input string tag);
      sw_in = sw;
      tick(3);
      key_in = 1'b0;
      tick(12);
      check({tag, "_pre_gate"}, gate_out, 1'b0);
      check({tag, "_pre_state"}, key_state, 1'b0);
      tick(1);
      exp_cnt = exp_cnt + 8'd1;
      check({tag, "_gate_on"}, gate_out, 1'b1);
      check({tag, "_d"}, d_out, sw);
      check({tag, "_cnt"}, press_cnt, exp_cnt);
      check({tag, "_state"}, key_state, 1'b1);
      tick(3);
      check({tag, "_gate_last"}, gate_out, 1'b1);
      tick(1);
      check({tag, "_gate_off"}, gate_out, 1'b0);
      key_in = 1'b1;
      tick(12);
      check({tag, "_rel_hold"}, key_state, 1'b1);
      tick(1);
      check({tag, "_rel_done"}, key_state, 1'b0);
   endtask

   task automatic press_quick();
      key_in = 1'b0;
      tick(18);
      key_in = 1'b1;
      tick(14);
      exp_cnt = exp_cnt + 8'd1;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      exp_cnt = 8'd0;
      rst_n   = 1'b0;
      key_in  = 1'b1;
      sw_in   = 1'b0;
      tick(3);
      rst_n = 1'b1;
      check("rst_d", d_out, 1'b0);
      check("rst_gate", gate_out, 1'b0);
      check("rst_state", key_state, 1'b0);
      check("rst_cnt", press_cnt, 8'd0);
      tick(3);

      // Clean press with switch high.
      rises0 = gate_rises;
      press_checked(1'b1, "clean");
      check("clean_one_pulse", gate_rises - rises0, 1);

      // Bounce: 6 low / 2 high never reaches the 10-count.
      rises0 = gate_rises;
      for (int i = 0; i < 5; i++) begin
         key_in = 1'b0;
         tick(6);
         key_in = 1'b1;
         tick(2);
      end
      tick(5);
      check("bounce_no_gate", gate_rises - rises0, 0);
      check("bounce_cnt", press_cnt, exp_cnt);
      check("bounce_state", key_state, 1'b0);

      // Release glitches must not drop key_state.
      rises0 = gate_rises;
      key_in = 1'b0;
      tick(16);
      exp_cnt = exp_cnt + 8'd1;
      check("relb_state", key_state, 1'b1);
      for (int i = 0; i < 3; i++) begin
         key_in = 1'b1;
         tick(3);
         key_in = 1'b0;
         tick(3);
         check("relb_glitch_state", key_state, 1'b1);
      end
      key_in = 1'b1;
      tick(12);
      check("relb_rel_hold", key_state, 1'b1);
      tick(1);
      check("relb_rel_done", key_state, 1'b0);
      tick(4);
      check("relb_one_pulse", gate_rises - rises0, 1);
      check("relb_cnt", press_cnt, exp_cnt);

      // Data hold: sw toggles every cycle; qualify samples sw_in set after edge 10 (= 0).
      sw_in  = 1'b0;
      key_in = 1'b0;
      for (int k = 1; k <= 24; k++) begin
         tick(1);
         if (k == 13) check("hold_gate_on", gate_out, 1'b1);
         if (k >= 13) check("hold_d", d_out, 1'b0);
         sw_in = ~sw_in;
      end
      exp_cnt = exp_cnt + 8'd1;
      check("hold_cnt", press_cnt, exp_cnt);
      key_in = 1'b1;
      tick(14);
      check("hold_d_after", d_out, 1'b0);

      // Asynchronous reset mid-gate, key still held.
      sw_in  = 1'b1;
      tick(3);
      key_in = 1'b0;
      tick(15);
      check("pre_rst_gate", gate_out, 1'b1);
      rst_n = 1'b0;
      #1;
      check("async_rst_gate", gate_out, 1'b0);
      check("async_rst_d", d_out, 1'b0);
      check("async_rst_state", key_state, 1'b0);
      check("async_rst_cnt", press_cnt, 8'd0);
      exp_cnt = 8'd0;
      tick(2);
      rst_n = 1'b1;
      tick(12);
      check("requal_pre_gate", gate_out, 1'b0);
      tick(1);
      exp_cnt = exp_cnt + 8'd1;
      check("requal_gate", gate_out, 1'b1);
      check("requal_cnt", press_cnt, exp_cnt);
      check("requal_d", d_out, 1'b1);
      key_in = 1'b1;
      tick(16);

      // Wrap: 255 more presses land on 0, one more on 1.
      rises0 = gate_rises;
      hi0    = gate_hi;
      for (int i = 0; i < 255; i++) press_quick();
      check("wrap_zero", press_cnt, 8'd0);
      press_quick();
      check("wrap_one", press_cnt, exp_cnt);
      check("wrap_pulses", gate_rises - rises0, 256);
      check("wrap_hi_cycles", gate_hi - hi0, 1024);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
